// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between n_req producers.
// An owner keeps the port for up to max_burst pushes, then yields to the next requester.
module fifo_push_arbiter #(
    parameter int bits      = 8,
    parameter int n_req     = 4,
    parameter int max_burst = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [n_req-1:0]          req,
    input  logic [n_req*bits-1:0]     din,
    input  logic                      fifo_full,
    output logic [n_req-1:0]          gnt,
    output logic                      fifo_push,
    output logic [bits-1:0]           fifo_din,
    output logic [$clog2(n_req)-1:0]  owner,
    output logic                      busy
);

    localparam int OW = $clog2(n_req);
    localparam int CW = $clog2(max_burst + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [OW-1:0] owner_nxt;
    logic          owner_req;
    logic          push;
    logic          last_push;
    logic          release_own;

    // First requester at or after ptr, wrapping modulo n_req.
    function automatic logic [OW-1:0] pick(input logic [n_req-1:0] r,
                                           input logic [OW-1:0]    ptr);
        logic          found;
        logic [OW-1:0] res;
        int            idx;
        found = 1'b0;
        res   = ptr;
        for (int k = 0; k < n_req; k++) begin
            idx = (int'(ptr) + k) % n_req;
            if (!found && r[idx]) begin
                res   = OW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign busy        = (state_q == BUSY);
    assign owner       = owner_q;
    assign owner_req   = req[owner_q];
    assign push        = busy & owner_req & ~fifo_full;
    assign fifo_push   = push;
    assign fifo_din    = din[owner_q*bits +: bits];
    assign owner_nxt   = (owner_q == OW'(n_req - 1)) ? '0 : owner_q + 1'b1;
    assign last_push   = push && (cnt_q == CW'(max_burst - 1));
    assign release_own = ~owner_req | last_push;

    always_comb begin
        gnt = '0;
        if (push) begin
            gnt[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = pick(req, rr_ptr_q);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (release_own) begin
                    // The released owner is scanned last, so it only wins again when alone.
                    rr_ptr_d = owner_nxt;
                    if (|req) begin
                        owner_d = pick(req, owner_nxt);
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (push) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Randomized bench for fifo_push_arbiter: producers and a depth-4 FIFO are modelled
// in the bench; a reference arbiter model predicts grants, owner and data each cycle.
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int B  = 8;
    localparam int MB = 4;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*B-1:0] din;
    logic           fifo_full;
    logic [N-1:0]   gnt;
    logic           fifo_push;
    logic [B-1:0]   fifo_din;
    logic [1:0]     owner;
    logic           busy;

    fifo_push_arbiter #(.bits(B), .n_req(N), .max_burst(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .fifo_full(fifo_full),
        .gnt(gnt), .fifo_push(fifo_push), .fifo_din(fifo_din),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Producer state and packed data bus
    logic [B-1:0] prod_word [N];
    int           rem [N];
    int           seq [N];

    always_comb begin
        din = '0;
        for (int i = 0; i < N; i++) din[i*B +: B] = prod_word[i];
    end

    // Reference arbiter model
    int  m_busy, m_owner, m_ptr, m_cnt;
    int  stall;
    logic [B-1:0] fq [$];

    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic drive_words();
        for (int i = 0; i < N; i++) prod_word[i] = {i[1:0], seq[i][5:0]};
    endtask

    int           exp_push;
    logic [N-1:0] exp_gnt;
    logic [B-1:0] exp_din;
    int           pushed_by;

    initial begin
        rst = 1'b1;
        req = '0;
        fifo_full = 1'b0;
        stall = 0;
        for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
        drive_words();
        model_reset();
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_gnt", gnt, 0);
        check_eq("rst_push", fifo_push, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_din", fifo_din, prod_word[0]);
        #6 rst = 1'b0;

        repeat (2000) begin
            @(negedge clk);
            exp_push = (m_busy != 0 && req[m_owner] && !fifo_full) ? 1 : 0;
            exp_gnt  = exp_push ? N'(1 << m_owner) : '0;
            exp_din  = prod_word[m_owner];
            check_eq("gnt", gnt, exp_gnt);
            check_eq("push", fifo_push, exp_push);
            check_eq("busy", busy, m_busy);
            check_eq("owner", owner, m_owner);
            check_eq("fifo_din", fifo_din, exp_din);
            if (fifo_full) check_eq("no_overflow", fifo_push, 0);

            @(posedge clk);
            pushed_by = exp_push ? m_owner : -1;
            if (m_busy == 0) begin
                if (req != 0) begin
                    m_owner = model_pick(req, m_ptr);
                    m_cnt = 0;
                    m_busy = 1;
                end
            end else begin
                if (exp_push != 0) m_cnt++;
                if (!req[m_owner] || m_cnt == MB) begin
                    m_ptr = (m_owner + 1) % N;
                    if (req != 0) begin
                        m_owner = model_pick(req, m_ptr);
                        m_cnt = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
            end
            if (exp_push != 0) fq.push_back(exp_din);
            if (fq.size() > 0 && $urandom_range(0, 2) == 0) void'(fq.pop_front());
            if (stall > 0) stall--;
            else if ($urandom_range(0, 19) == 0) stall = $urandom_range(1, 3);

            #1;
            for (int i = 0; i < N; i++) begin
                if (pushed_by == i) begin
                    seq[i]++;
                    rem[i]--;
                    if ($urandom_range(0, 9) == 0) rem[i] = 0;
                end
                if (req[i]) begin
                    if (rem[i] <= 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 7);
                    req[i] = 1'b1;
                end
            end
            drive_words();
            fifo_full = (fq.size() >= DEPTH) || (stall > 0);
        end

        // All producers requesting: owners rotate 0,1,2,3 with MB pushes each.
        @(posedge clk); #1;
        fifo_full = 1'b0;
        req = '1;
        rst = 1'b1;
        #2 rst = 1'b0;
        for (int k = 0; k < 4 * N; k++) begin
            @(posedge clk); #1;
            check_eq("rot_owner", owner, k / MB);
            check_eq("rot_push", fifo_push, 1);
        end

        // Reset mid-burst, then a lone request from producer 3.
        @(posedge clk); #1;
        req = 4'b0110;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("sel_owner", owner, 1);
        check_eq("sel_gnt", gnt, 4'b0010);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_gnt", gnt, 0);
        check_eq("mid_rst_push", fifo_push, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_din", fifo_din, prod_word[0]);
        req = 4'b1000;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_owner", owner, 3);
        check_eq("post_rst_gnt", gnt, 4'b1000);
        check_eq("post_rst_busy", busy, 1);
        check_eq("post_rst_din", fifo_din, prod_word[3]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
